// File: rtl/dmem_scrub_ctrl.sv
// rtl/dmem_scrub_ctrl.sv - background SECDED scrubber for the data memory
// Reads one word per interval, writes back corrected data, counts and reports errors.
module dmem_scrub_ctrl #(
   parameter int AW       = 8,
   parameter int DEPTH    = 256,
   parameter int CW       = 39,
   parameter int INTERVAL = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [CW-1:0] mem_wdata,
   input  logic          dec_sbe,
   input  logic          dec_dbe,
   input  logic [CW-1:0] dec_cw,
   input  logic          clr_cnt,
   output logic [15:0]   sbe_cnt,
   output logic [15:0]   dbe_cnt,
   output logic          dbe_irq,
   output logic [AW-1:0] dbe_addr,
   output logic          pass_done,
   output logic          busy
);

   localparam int            IW        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [IW-1:0] IVAL_LOAD = IW'(INTERVAL - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_CHK, S_WB} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ival_q, ival_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] wdata_q, wdata_d;
   logic [15:0]   sbe_cnt_q, sbe_cnt_d;
   logic [15:0]   dbe_cnt_q, dbe_cnt_d;
   logic          dbe_irq_q, dbe_irq_d;
   logic [AW-1:0] dbe_addr_q, dbe_addr_d;
   logic          pass_done_q, pass_done_d;
   logic          stop_q, stop_d;

   logic store_hit, stopping, advance, sbe_inc, dbe_inc;

   always_comb begin
      state_d     = state_q;
      ival_d      = ival_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      dbe_addr_d  = dbe_addr_q;
      stop_d      = stop_q;
      dbe_irq_d   = 1'b0;
      pass_done_d = 1'b0;
      advance     = 1'b0;
      sbe_inc     = 1'b0;
      dbe_inc     = 1'b0;
      // A CPU store to the word under repair makes our corrected copy stale.
      store_hit   = cpu_req & cpu_we & (cpu_addr == addr_q);
      stopping    = stop_q | ~en;

      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_WAIT;
               ival_d  = IVAL_LOAD;
            end
         end
         S_WAIT: begin
            if (!en) begin
               state_d = S_IDLE;
            end else if (ival_q == '0) begin
               state_d = S_RD;
            end else begin
               ival_d = ival_q - 1'b1;
            end
         end
         S_RD: begin
            stop_d = stopping;
            if (!cpu_req) begin
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            stop_d = stopping;
            if (dec_dbe) begin
               dbe_inc    = 1'b1;
               dbe_irq_d  = 1'b1;
               dbe_addr_d = addr_q;
               advance    = 1'b1;
            end else if (dec_sbe) begin
               if (store_hit) begin
                  sbe_inc = 1'b1;
                  advance = 1'b1;
               end else begin
                  wdata_d = dec_cw;
                  state_d = S_WB;
               end
            end else begin
               advance = 1'b1;
            end
         end
         S_WB: begin
            stop_d = stopping;
            if (store_hit || !cpu_req) begin
               sbe_inc = 1'b1;
               advance = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
         pass_done_d = (addr_q == LAST_ADDR);
         stop_d      = 1'b0;
         if (stopping) begin
            state_d = S_IDLE;
         end else begin
            state_d = S_WAIT;
            ival_d  = IVAL_LOAD;
         end
      end

      if (clr_cnt)                              sbe_cnt_d = '0;
      else if (sbe_inc && sbe_cnt_q != 16'hFFFF) sbe_cnt_d = sbe_cnt_q + 16'd1;
      else                                      sbe_cnt_d = sbe_cnt_q;

      if (clr_cnt)                              dbe_cnt_d = '0;
      else if (dbe_inc && dbe_cnt_q != 16'hFFFF) dbe_cnt_d = dbe_cnt_q + 16'd1;
      else                                      dbe_cnt_d = dbe_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ival_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         sbe_cnt_q   <= '0;
         dbe_cnt_q   <= '0;
         dbe_irq_q   <= 1'b0;
         dbe_addr_q  <= '0;
         pass_done_q <= 1'b0;
         stop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ival_q      <= ival_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         sbe_cnt_q   <= sbe_cnt_d;
         dbe_cnt_q   <= dbe_cnt_d;
         dbe_irq_q   <= dbe_irq_d;
         dbe_addr_q  <= dbe_addr_d;
         pass_done_q <= pass_done_d;
         stop_q      <= stop_d;
      end
   end

   // Port ownership is gated combinationally so the CPU always wins the same cycle.
   assign mem_req   = ~cpu_req & ((state_q == S_RD) | (state_q == S_WB));
   assign mem_we    = ~cpu_req & (state_q == S_WB);
   assign busy      = (state_q == S_RD) | (state_q == S_CHK) | (state_q == S_WB);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign sbe_cnt   = sbe_cnt_q;
   assign dbe_cnt   = dbe_cnt_q;
   assign dbe_irq   = dbe_irq_q;
   assign dbe_addr  = dbe_addr_q;
   assign pass_done = pass_done_q;

endmodule

// File: doc/dmem_scrub_ctrl.md
DMEM_SCRUB_CTRL -- requirements
Module: dmem_scrub_ctrl

Interface
REQ-001 Parameter AW, default 8, data-memory word-address width.
REQ-002 Parameter DEPTH, default 256, number of words scrubbed per pass (<= 2^AW).
REQ-003 Parameter CW, default 39, Hamming SECDED codeword width (32 data + 7 check).
REQ-004 Parameter INTERVAL, default 1024, idle cycles between successive scrub reads (>= 1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  scrub enable (driven by loader done).
REQ-008 cpu_req  in  1  CPU pipeline accesses dmem this cycle; always has priority.
REQ-009 cpu_we  in  1  CPU access is a store.
REQ-010 cpu_addr  in  AW  CPU word address.
REQ-011 mem_req  out  1  scrubber owns the dmem port this cycle.
REQ-012 mem_we  out  1  scrubber write strobe (valid only with mem_req).
REQ-013 mem_addr  out  AW  scrubber word address.
REQ-014 mem_wdata  out  CW  corrected codeword for write-back.
REQ-015 dec_sbe  in  1  decoder single-bit-error flag for the previous-cycle read.
REQ-016 dec_dbe  in  1  decoder double-bit-error flag for the previous-cycle read.
REQ-017 dec_cw  in  CW  decoder-corrected codeword for the previous-cycle read.
REQ-018 clr_cnt  in  1  synchronous clear of sbe_cnt, dbe_cnt.
REQ-019 sbe_cnt  out  16  corrected-error count, saturating.
REQ-020 dbe_cnt  out  16  uncorrectable-error count, saturating.
REQ-021 dbe_irq  out  1  one-cycle pulse on uncorrectable error.
REQ-022 dbe_addr  out  AW  address of most recent uncorrectable error.
REQ-023 pass_done  out  1  one-cycle pulse when address wraps DEPTH-1 -> 0.
REQ-024 busy  out  1  high in any state other than IDLE/WAIT.

Function
REQ-025 FSM states IDLE, WAIT, RD, CHK, WB shall be implemented.
REQ-026 IDLE: en=1 -> WAIT with interval counter loaded to INTERVAL-1; else stay.
REQ-027 WAIT: counter decrements each cycle; at 0 -> RD; en=0 -> IDLE immediately.
REQ-028 RD: mem_req=1, mem_we=0 only when cpu_req=0 (combinational gating); grant -> CHK next cycle; cpu_req=1 -> stay in RD.
REQ-029 CHK samples dec_* exactly one cycle after the granted read.
REQ-030 CHK: dec_dbe=1 -> dbe_cnt+1, dbe_irq pulse, dbe_addr<=mem_addr, no write-back, advance.
REQ-031 CHK: dec_sbe=1 (dbe=0) -> latch dec_cw into mem_wdata, -> WB.
REQ-032 CHK: no error -> advance; advance = address+1 (DEPTH-1 wraps to 0 with pass_done), then WAIT.
REQ-033 WB: mem_req=1, mem_we=1 when cpu_req=0; on grant sbe_cnt+1, advance; cpu_req=1 -> hold.
REQ-034 CPU store (cpu_req&cpu_we) to cpu_addr==mem_addr while in CHK or WB shall cancel the write-back (no write, sbe_cnt still +1), then advance.
REQ-035 Counters saturate at 16'hFFFF; clr_cnt beats same-cycle increment.
REQ-036 en=0 in RD/CHK/WB completes the current word, then IDLE instead of WAIT.
REQ-037 mem_req never asserts in the same cycle as cpu_req.

Reset
REQ-038 rst=0 asynchronously forces IDLE, address 0, counters 0, mem_req/mem_we/dbe_irq/pass_done/busy 0, mem_wdata 0, dbe_addr 0.
REQ-039 Reset mid-WB shall drop the write with no memory update after reset asserts.

Verification
REQ-040 INTERVAL=4, en=1, clean memory -> first mem_req 5 cycles after en; addresses 0,1,2... one per 6 cycles; no writes.
REQ-041 Flip bit 3 of mem[1] (dec_sbe=1) -> write of dec_cw to addr 1, sbe_cnt=1, re-read of mem[1] decodes clean.
REQ-042 Flip bits 5,6 of mem[1] (dec_dbe=1) -> no write, dbe_cnt=1, dbe_irq one cycle, dbe_addr=1.
REQ-043 cpu_req held 10 cycles during RD -> mem_req stays 0 those cycles, read issued on cycle after release.
REQ-044 CPU store to addr 1 during WB of addr 1 -> write-back suppressed, CPU data survives in mem[1].
REQ-045 DEPTH=4 full pass -> pass_done single pulse on 3->0 wrap; rst=0 during WB -> all outputs 0, no write.
